sfu_bank: RTL and testbench

Multi-column, multi-address successor to the single-register special function unit. It accumulates one signed partial sum per column into a per-address register file, with saturation, an overwrite (first-pass) mode, and a read-and-clear drain sequence that applies optional ReLU. It sits between the systolic-array output FIFO and the output SRAM write path: one `in` vector per array output row, one `out` vector per drained address.

---
 rtl/sfu_pkg.sv | 41 ++++
 rtl/sfu_lane.sv | 63 ++++++
 rtl/sfu_bank.sv | 111 +++++++++++
 tb/tb_sfu_bank.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sfu_pkg.sv
// Shared types and arithmetic helpers for the special function unit bank.
package sfu_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Saturated sum carried at full 64-bit width; callers size-cast to their lane width.
  typedef struct packed {
    logic signed [63:0] val;
    logic               ovf;
  } sat_t;

  // Add two values and clip the result to a signed w-bit range.
  function automatic sat_t sat_add(input longint a, input longint b, input int unsigned w);
    longint s;
    longint hi;
    longint lo;
    sat_t   r;
    s     = a + b;
    hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo    = -hi - 64'sd1;
    r.val = s;
    r.ovf = 1'b0;
    if (s > hi) begin
      r.val = hi;
      r.ovf = 1'b1;
    end else if (s < lo) begin
      r.val = lo;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

  // Clamp negative values to zero.
  function automatic longint relu(input longint x);
    return (x < 0) ? 64'sd0 : x;
  endfunction

endpackage

// File: rtl/sfu_lane.sv
// One column: per-address accumulator file, saturating adder, ReLU mux, output register.
module sfu_lane
  import sfu_pkg::*;
#(
  parameter int psum_bw = 16,
  parameter int depth   = 16,
  localparam int aw     = $clog2(depth)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_wr_en,
  input  logic                      i_first,
  input  logic [aw-1:0]             i_wr_addr,
  input  logic signed [psum_bw-1:0] i_din,
  input  logic                      i_rd_en,
  input  logic [aw-1:0]             i_rd_addr,
  input  logic                      i_relu_en,
  output logic signed [psum_bw-1:0] o_dout,
  output logic                      o_ovf
);

  logic signed [psum_bw-1:0] r_mem [depth];
  logic signed [psum_bw-1:0] r_dout;
  logic signed [psum_bw-1:0] w_cur;
  logic signed [psum_bw-1:0] w_wr_val;
  logic signed [psum_bw-1:0] w_rd;
  logic signed [psum_bw-1:0] w_rd_act;
  sat_t                      w_sat;

  // Accumulate path: read-modify-write of the addressed entry, or overwrite on first pass.
  always_comb begin
    w_cur    = r_mem[i_wr_addr];
    w_sat    = sat_add(longint'(w_cur), longint'(i_din), psum_bw);
    w_wr_val = i_first ? i_din : psum_bw'(w_sat.val);
    o_ovf    = i_wr_en & ~i_first & w_sat.ovf;
  end

  // Drain path: stored values stay raw, ReLU is applied only on the way out.
  always_comb begin
    w_rd     = r_mem[i_rd_addr];
    w_rd_act = i_relu_en ? psum_bw'(relu(longint'(w_rd))) : w_rd;
  end

  // Register file: writes happen only in IDLE, read-and-clear only in DRAIN, so they never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= w_wr_val;
    end else if (i_rd_en) begin
      r_mem[i_rd_addr] <= '0;
    end
  end

  // Output register holds its value between drain beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_dout <= '0;
    else if (i_rd_en) r_dout <= w_rd_act;
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/sfu_bank.sv
// Multi-column accumulator bank with drain sequencing and sticky error flags.
module sfu_bank
  import sfu_pkg::*;
#(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int depth   = 16,
  localparam int aw     = $clog2(depth)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_first,
  input  logic [aw-1:0]          in_addr,
  input  logic [col*psum_bw-1:0] in,
  input  logic                   relu_en,
  input  logic                   drain_start,
  output logic                   busy,
  output logic                   out_valid,
  output logic [aw-1:0]          out_addr,
  output logic [col*psum_bw-1:0] out,
  output logic                   ovf_err,
  output logic                   drop_err
);

  state_e         r_state;
  state_e         w_state_nxt;
  logic [aw-1:0]  r_cnt;
  logic           r_out_valid;
  logic [aw-1:0]  r_out_addr;
  logic           r_ovf;
  logic           r_drop;
  logic           w_wr_en;
  logic           w_rd_en;
  logic           w_drop;
  logic [col-1:0] w_lane_ovf;

  assign w_wr_en = in_valid & (r_state == IDLE);
  assign w_rd_en = (r_state == DRAIN);
  assign w_drop  = in_valid & (r_state == DRAIN);

  // Next-state logic: a drain always runs the full address range once started.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (drain_start) w_state_nxt = DRAIN;
      DRAIN:   if (r_cnt == aw'(depth - 1)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Drain counter wraps to zero after the last beat, so it is ready for the next pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_cnt <= '0;
    else if (w_rd_en) r_cnt <= r_cnt + 1'b1;
  end

  // Output beat qualifiers line up with the lanes' registered data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
    end else begin
      r_out_valid <= w_rd_en;
      if (w_rd_en) r_out_addr <= r_cnt;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      if (|w_lane_ovf) r_ovf  <= 1'b1;
      if (w_drop)      r_drop <= 1'b1;
    end
  end

  for (genvar k = 0; k < col; k++) begin : g_lane
    sfu_lane #(
      .psum_bw(psum_bw),
      .depth  (depth)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .i_wr_en  (w_wr_en),
      .i_first  (in_first),
      .i_wr_addr(in_addr),
      .i_din    (in[k*psum_bw +: psum_bw]),
      .i_rd_en  (w_rd_en),
      .i_rd_addr(r_cnt),
      .i_relu_en(relu_en),
      .o_dout   (out[k*psum_bw +: psum_bw]),
      .o_ovf    (w_lane_ovf[k])
    );
  end

  assign busy      = (r_state == DRAIN);
  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;
  assign ovf_err   = r_ovf;
  assign drop_err  = r_drop;

endmodule

// File: tb/tb_sfu_bank.sv
// Randomized and directed bench for sfu_bank against a behavioural model.
module tb_sfu_bank;
  localparam int PW = 16;
  localparam int C  = 4;
  localparam int D  = 4;
  localparam int AW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_first = 1'b0;
  logic [AW-1:0]   in_addr = '0;
  logic [C*PW-1:0] in_v = '0;
  logic            relu_en = 1'b0;
  logic            drain_start = 1'b0;
  logic            busy;
  logic            out_valid;
  logic [AW-1:0]   out_addr;
  logic [C*PW-1:0] out_v;
  logic            ovf_err;
  logic            drop_err;

  sfu_bank #(.psum_bw(PW), .col(C), .depth(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .in_addr(in_addr), .in(in_v), .relu_en(relu_en), .drain_start(drain_start),
    .busy(busy), .out_valid(out_valid), .out_addr(out_addr), .out(out_v),
    .ovf_err(ovf_err), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int model [D][C];
  bit exp_ovf  = 1'b0;
  bit exp_drop = 1'b0;
  int zero4 [C] = '{0, 0, 0, 0};

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int clip(input int x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic int lane_out(input int k);
    logic signed [PW-1:0] v;
    v = out_v[k*PW +: PW];
    return int'(v);
  endfunction

  task automatic drive_lanes(input int v [C]);
    for (int k = 0; k < C; k++) in_v[k*PW +: PW] = PW'(v[k]);
  endtask

  // Model of one accepted write: overwrite on first pass, otherwise clipped add.
  task automatic model_write(input int addr, input bit first, input int v [C]);
    for (int k = 0; k < C; k++) begin
      if (first) model[addr][k] = v[k];
      else begin
        if (clip(model[addr][k] + v[k]) != model[addr][k] + v[k]) exp_ovf = 1'b1;
        model[addr][k] = clip(model[addr][k] + v[k]);
      end
    end
  endtask

  task automatic acc(input int addr, input bit first, input int v [C]);
    in_valid = 1'b1;
    in_first = first;
    in_addr  = AW'(addr);
    drive_lanes(v);
    model_write(addr, first, v);
    step();
    in_valid = 1'b0;
    in_first = 1'b0;
    check("ovf_after_acc", ovf_err, exp_ovf);
  endtask

  // Full drain with optional dropped write (at beat drop_c), ignored re-trigger
  // (at beat retrig_c) and a write issued in the same cycle as drain_start.
  task automatic drain(input bit relu, input int drop_c, input int retrig_c,
                       input bit sim_wr, input int sw_addr, input int sw_v [C]);
    int ex [D][C];
    drain_start = 1'b1;
    relu_en     = relu;
    if (sim_wr) begin
      in_valid = 1'b1;
      in_first = 1'b0;
      in_addr  = AW'(sw_addr);
      drive_lanes(sw_v);
      model_write(sw_addr, 1'b0, sw_v);
    end
    for (int a = 0; a < D; a++)
      for (int k = 0; k < C; k++) begin
        ex[a][k]    = (relu && model[a][k] < 0) ? 0 : model[a][k];
        model[a][k] = 0;
      end
    step();
    drain_start = 1'b0;
    in_valid    = 1'b0;
    check("busy_first", busy, 1);
    check("ovalid_first", out_valid, 0);
    for (int c = 0; c < D; c++) begin
      if (c == drop_c) begin
        in_valid = 1'b1;
        in_addr  = AW'(D - 1);
        drive_lanes('{1111, 2222, -3333, 4444});
        exp_drop = 1'b1;
      end
      if (c == retrig_c) drain_start = 1'b1;
      step();
      in_valid    = 1'b0;
      drain_start = 1'b0;
      check("out_valid", out_valid, 1);
      check("out_addr", out_addr, c);
      check("busy_beat", busy, (c < D - 1) ? 1 : 0);
      for (int k = 0; k < C; k++) check($sformatf("out[%0d][%0d]", c, k), lane_out(k), ex[c][k]);
    end
    check("drop_err", drop_err, exp_drop);
    check("ovf_err", ovf_err, exp_ovf);
    step();
    check("ovalid_end", out_valid, 0);
    check("busy_end", busy, 0);
    for (int k = 0; k < C; k++) check("out_hold", lane_out(k), ex[D-1][k]);
  endtask

  initial begin
    int v [C];
    for (int a = 0; a < D; a++) for (int k = 0; k < C; k++) model[a][k] = 0;

    // Reset
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_ovalid", out_valid, 0);
    check("rst_oaddr", out_addr, 0);
    check("rst_out", out_v, 0);
    check("rst_ovf", ovf_err, 0);
    check("rst_drop", drop_err, 0);
    rst = 1'b0;
    step();

    // 1: accumulate and drain
    acc(1, 1'b1, '{5, 5, 5, 5});
    acc(1, 1'b0, '{3, 3, 3, 3});
    acc(1, 1'b0, '{-10, -10, -10, -10});
    drain(1'b0, -1, -1, 1'b0, 0, zero4);
    step();

    // 2: ReLU and clear
    acc(1, 1'b1, '{5, 5, 5, 5});
    acc(1, 1'b0, '{3, 3, 3, 3});
    acc(1, 1'b0, '{-10, -10, -10, -10});
    drain(1'b1, -1, -1, 1'b0, 0, zero4);
    drain(1'b0, -1, -1, 1'b0, 0, zero4);
    check("ovf_clear_scen", ovf_err, 0);

    // 3: saturation
    acc(0, 1'b1, '{11, -7, 32000, -32000});
    acc(0, 1'b0, '{1, 1, 1000, -1000});
    check("ovf_sat", ovf_err, 1);
    drain(1'b0, -1, -1, 1'b0, 0, zero4);

    // 4: drop, ignored re-trigger, simultaneous write+start
    acc(2, 1'b1, '{1, 2, 3, 4});
    check("drop_pre", drop_err, 0);
    drain(1'b0, 1, 2, 1'b1, 3, '{4, -4, 100, -100});
    check("drop_post", drop_err, 1);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      int nops;
      nops = int'($urandom_range(1, 6));
      for (int o = 0; o < nops; o++) begin
        for (int k = 0; k < C; k++)
          v[k] = ($urandom_range(0, 2) == 0) ? (int'($urandom_range(0, 65535)) - 32768)
                                              : (int'($urandom_range(0, 200)) - 100);
        acc(int'($urandom_range(0, D - 1)), ($urandom_range(0, 3) == 0), v);
      end
      drain(bit'($urandom_range(0, 1)), -1, -1, 1'b0, 0, zero4);
    end

    // 5: reset mid-drain
    for (int a = 0; a < D; a++) acc(a, 1'b1, '{a + 1, -(a + 1), 77, -77});
    drain_start = 1'b1;
    step();
    drain_start = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ovalid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ovf", ovf_err, 0);
    check("mid_rst_drop", drop_err, 0);
    for (int a = 0; a < D; a++) for (int k = 0; k < C; k++) model[a][k] = 0;
    exp_ovf  = 1'b0;
    exp_drop = 1'b0;
    #1 rst = 1'b0;
    step();
    drain(1'b0, -1, -1, 1'b0, 0, zero4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
